// File: rtl/insn_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with registered Moore strobes.
// Optional memory-access timeout enabled by defining SEQ_MEM_TIMEOUT_EN.
module insn_sequencer #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 dec_halt,
    input  logic                 dec_regWrite,
    input  logic                 dec_memoryRead,
    input  logic                 dec_memoryWrite,
    input  logic                 mem_ack,
    output logic                 ir_load,
    output logic                 pc_we,
    output logic                 reg_we,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 halted,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Reject a timeout that could never allow even a single MEM cycle.
    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("insn_sequencer: MEM_TIMEOUT must be at least 1");
    end

    state_t                state_q, state_d;
    logic                  rw_q, rw_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  timeout_s;
    logic                  ir_load_q, ir_load_d;
    logic                  pc_we_q, pc_we_d;
    logic                  reg_we_q, reg_we_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q, mem_err_d;

    // Wait counter: cleared on MEM entry, counts ack-less MEM cycles, flags timeout.
    always_comb begin
        wait_d    = wait_q;
        timeout_s = 1'b0;
        if (state_q == S_MEM) begin
            if (mem_ack) begin
                wait_d = {WAIT_W{1'b0}};
            end else begin
                timeout_s = (wait_q == WAIT_LAST);
                wait_d    = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            wait_d = {WAIT_W{1'b0}};
        end
        mem_err_d = mem_err_q | timeout_s;
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q    <= {WAIT_W{1'b0}};
            mem_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign timeout_s = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Next-state logic and decode-flag capture.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                // Halt overrides every other decoded flag.
                if (dec_halt) begin
                    rw_d    = 1'b0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_HALT;
                end else begin
                    rw_d    = dec_regWrite;
                    rd_d    = dec_memoryRead;
                    wr_d    = dec_memoryWrite;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (rd_q || wr_q) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A same-cycle ack beats the timeout.
                if (mem_ack) begin
                    state_d = S_WB;
                end else if (timeout_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the registered outputs track the state register.
    always_comb begin
        ir_load_d = (state_d == S_FETCH);
        pc_we_d   = (state_d == S_WB);
        reg_we_d  = (state_d == S_WB) && rw_d;
        mem_req_d = (state_d == S_MEM);
        mem_we_d  = (state_d == S_MEM) && wr_d && !rd_d;
        busy_d    = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d  = (state_d == S_HALT);
        if ((state_d == S_WB) && (retired_q != CNT_MAX)) begin
            retired_d = retired_q + CNT_ONE;
        end else begin
            retired_d = retired_q;
        end
    end

    // State, latched flags and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rw_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ir_load_q <= 1'b0;
            pc_we_q   <= 1'b0;
            reg_we_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            ir_load_q <= ir_load_d;
            pc_we_q   <= pc_we_d;
            reg_we_q  <= reg_we_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign ir_load = ir_load_q;
    assign pc_we   = pc_we_q;
    assign reg_we  = reg_we_q;
    assign mem_req = mem_req_q;
    assign mem_we  = mem_we_q;
    assign busy    = busy_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// Directed bench for insn_sequencer (CNT_WIDTH=4); timeout scenario follows SEQ_MEM_TIMEOUT_EN.
module tb_insn_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       dec_halt = 1'b0;
    logic       dec_regWrite = 1'b0;
    logic       dec_memoryRead = 1'b0;
    logic       dec_memoryWrite = 1'b0;
    logic       mem_ack = 1'b0;
    logic       ir_load, pc_we, reg_we, mem_req, mem_we, busy, halted, mem_err;
    logic [3:0] retired;
    logic [6:0] outs_s;
    int         checks = 0;
    int         failures = 0;

    // outs = {ir_load, pc_we, reg_we, mem_req, mem_we, busy, halted}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_FETCH = 7'b1000010;
    localparam logic [6:0] O_DEC   = 7'b0000010;
    localparam logic [6:0] O_WB_R  = 7'b0110010;
    localparam logic [6:0] O_WB_N  = 7'b0100010;
    localparam logic [6:0] O_MEM_R = 7'b0001010;
    localparam logic [6:0] O_MEM_W = 7'b0001110;
    localparam logic [6:0] O_HALT  = 7'b0000001;

    assign outs_s = {ir_load, pc_we, reg_we, mem_req, mem_we, busy, halted};

    insn_sequencer #(.CNT_WIDTH(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dec_halt(dec_halt),
        .dec_regWrite(dec_regWrite), .dec_memoryRead(dec_memoryRead),
        .dec_memoryWrite(dec_memoryWrite), .mem_ack(mem_ack),
        .ir_load(ir_load), .pc_we(pc_we), .reg_we(reg_we), .mem_req(mem_req),
        .mem_we(mem_we), .busy(busy), .halted(halted), .mem_err(mem_err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; dec_halt = 1'b0; dec_regWrite = 1'b0;
        dec_memoryRead = 1'b0; dec_memoryWrite = 1'b0; mem_ack = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        checks++;
        if ({outs_s, mem_err, retired} !== {O_IDLE, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL reset_values outs=%b err=%b ret=%h exp=%b 0 0", outs_s, mem_err, retired, O_IDLE);
        end
        do_reset();
        tick(); tick();
        checks++;
        if (outs_s !== O_IDLE) begin
            failures++;
            $display("FAIL idle_no_start outs=%b exp=%b", outs_s, O_IDLE);
        end
    endtask

    task automatic test_alu();
        do_reset();
        dec_regWrite = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (outs_s !== O_FETCH) begin failures++; $display("FAIL alu_fetch outs=%b exp=%b", outs_s, O_FETCH); end
        tick();
        checks++;
        if (outs_s !== O_DEC) begin failures++; $display("FAIL alu_decode outs=%b exp=%b", outs_s, O_DEC); end
        tick();
        dec_regWrite = 1'b0;
        tick();
        checks++;
        if (outs_s !== O_WB_R) begin failures++; $display("FAIL alu_wb outs=%b exp=%b", outs_s, O_WB_R); end
        tick();
        checks++;
        if ({outs_s, retired} !== {O_FETCH, 4'h1}) begin
            failures++; $display("FAIL alu_refetch outs=%b ret=%h exp=%b 1", outs_s, retired, O_FETCH);
        end
    endtask

    task automatic test_load();
        int req_cnt = 0;
        int we_cnt = 0;
        do_reset();
        dec_regWrite = 1'b1; dec_memoryRead = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            req_cnt += int'(mem_req);
            we_cnt  += int'(mem_we);
            if (i == 2) mem_ack = 1'b1;
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({req_cnt, we_cnt} !== {32'd3, 32'd0}) begin
            failures++; $display("FAIL load_req_cycles req=%0d we=%0d exp=3 0", req_cnt, we_cnt);
        end
        checks++;
        if (outs_s !== O_WB_R) begin failures++; $display("FAIL load_wb outs=%b exp=%b", outs_s, O_WB_R); end
        tick();
        checks++;
        if ({outs_s, retired} !== {O_FETCH, 4'h1}) begin
            failures++; $display("FAIL load_retire outs=%b ret=%h exp=%b 1", outs_s, retired, O_FETCH);
        end
    endtask

    task automatic test_store();
        do_reset();
        dec_memoryWrite = 1'b1; mem_ack = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (outs_s !== O_MEM_W) begin failures++; $display("FAIL store_mem outs=%b exp=%b", outs_s, O_MEM_W); end
        tick();
        checks++;
        if (outs_s !== O_WB_N) begin failures++; $display("FAIL store_wb outs=%b exp=%b", outs_s, O_WB_N); end
        tick();
        dec_memoryRead = 1'b1;
        checks++;
        if ({outs_s, retired} !== {O_FETCH, 4'h1}) begin
            failures++; $display("FAIL store_retire outs=%b ret=%h exp=%b 1", outs_s, retired, O_FETCH);
        end
        tick(); tick(); tick();
        checks++;
        if (outs_s !== O_MEM_R) begin failures++; $display("FAIL rw_read_wins outs=%b exp=%b", outs_s, O_MEM_R); end
        tick(); tick();
        checks++;
        if (retired !== 4'h2) begin failures++; $display("FAIL rw_retire ret=%h exp=2", retired); end
        mem_ack = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        dec_halt = 1'b1; dec_regWrite = 1'b1; dec_memoryWrite = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        checks++;
        if ({outs_s, retired} !== {O_HALT, 4'h0}) begin
            failures++; $display("FAIL halt_enter outs=%b ret=%h exp=%b 0", outs_s, retired, O_HALT);
        end
        for (int i = 0; i < 6; i++) begin
            start = i[0]; mem_ack = ~i[0];
            tick();
        end
        start = 1'b0; mem_ack = 1'b0;
        checks++;
        if ({outs_s, retired, mem_err} !== {O_HALT, 4'h0, 1'b0}) begin
            failures++; $display("FAIL halt_sticky outs=%b ret=%h err=%b exp=%b 0 0", outs_s, retired, mem_err, O_HALT);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        dec_regWrite = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        dec_regWrite = 1'b0; dec_memoryRead = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({outs_s, retired} !== {O_MEM_R, 4'h1}) begin
            failures++; $display("FAIL pre_reset_mem outs=%b ret=%h exp=%b 1", outs_s, retired, O_MEM_R);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({outs_s, retired, mem_err} !== {O_IDLE, 4'h0, 1'b0}) begin
            failures++; $display("FAIL async_reset outs=%b ret=%h err=%b exp=%b 0 0", outs_s, retired, mem_err, O_IDLE);
        end
        do_reset();
    endtask

    task automatic test_saturate();
        do_reset();
        dec_regWrite = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        checks++;
        if ({outs_s, retired} !== {O_FETCH, 4'hF}) begin
            failures++; $display("FAIL sat_15 outs=%b ret=%h exp=%b f", outs_s, retired, O_FETCH);
        end
        repeat (3) tick();
        checks++;
        if (outs_s !== O_WB_R) begin failures++; $display("FAIL sat_16_wb outs=%b exp=%b", outs_s, O_WB_R); end
        tick();
        checks++;
        if (retired !== 4'hF) begin failures++; $display("FAIL sat_hold ret=%h exp=f", retired); end
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        do_reset();
        dec_memoryRead = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
`ifdef SEQ_MEM_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            req_cnt += int'(mem_req);
        end
        tick();
        checks++;
        if ({req_cnt, outs_s, mem_err, retired} !== {32'd15, O_HALT, 1'b1, 4'h0}) begin
            failures++;
            $display("FAIL timeout_halt req=%0d outs=%b err=%b ret=%h exp=15 %b 1 0", req_cnt, outs_s, mem_err, retired, O_HALT);
        end
        do_reset();
        checks++;
        if (mem_err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear err=%b exp=0", mem_err); end
        dec_memoryRead = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 14) mem_ack = 1'b1;
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({outs_s, mem_err} !== {O_WB_N, 1'b0}) begin
            failures++; $display("FAIL timeout_ack_wins outs=%b err=%b exp=%b 0", outs_s, mem_err, O_WB_N);
        end
        tick();
        checks++;
        if (retired !== 4'h1) begin failures++; $display("FAIL timeout_ack_retire ret=%h exp=1", retired); end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            req_cnt += int'(mem_req);
        end
        checks++;
        if ({req_cnt, outs_s, mem_err} !== {32'd20, O_MEM_R, 1'b0}) begin
            failures++;
            $display("FAIL mem_wait_forever req=%0d outs=%b err=%b exp=20 %b 0", req_cnt, outs_s, mem_err, O_MEM_R);
        end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_halt();
        test_reset_mid_mem();
        test_saturate();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insn_sequencer.md
Name: insn_sequencer

Overview:
- Multi-cycle sequencer for the single-issue core; sits between instruction ROM/fetch, the decode unit, the register file and data memory.
- Steps each instruction through FETCH, DECODE, EXEC, MEM, WB. Issues one-cycle enable strobes and runs a req/ack handshake with data memory.
- Owns the halted state and a retired-instruction counter.

Parameters:
CNT_WIDTH, 16, width of retired-instruction counter
MEM_TIMEOUT, 15, max MEM cycles without ack (only with optional feature)

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin execution from IDLE
dec_halt  input  1  decoded halt signal
dec_regWrite  input  1  decoded register-file write
dec_memoryRead  input  1  decoded data-memory read
dec_memoryWrite  input  1  decoded data-memory write
mem_ack  input  1  data memory completes current access
ir_load  output  1  latch ROM word into instruction register
pc_we  output  1  fetch unit updates PC (next/branch/jump)
reg_we  output  1  register-file write strobe
mem_req  output  1  data-memory access request
mem_we  output  1  request is a write (valid while mem_req)
busy  output  1  not in IDLE or HALT
halted  output  1  in HALT
mem_err  output  1  sticky memory timeout flag
retired  output  CNT_WIDTH  count of completed instructions

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, reset_n).
  - reset_n low forces state IDLE immediately, mid-instruction included.
  - All outputs 0; retired=0; mem_err=0; latched decode flags cleared.
  - No strobe may glitch high while reset_n is low.
- Outputs are Moore: decoded from state and latched flags only.
- States and transitions:
  - IDLE: all strobes 0. start=1 at edge -> FETCH. start while busy or halted is ignored.
  - FETCH: ir_load=1 for exactly 1 cycle -> DECODE.
  - DECODE:
    - Latch dec_regWrite, dec_memoryRead, dec_memoryWrite.
    - dec_halt=1 -> HALT. The halt takes priority over all other decoded flags and nothing is retired.
    - Otherwise -> EXEC.
  - EXEC: 1 cycle for the ALU. Latched read or write set -> MEM; else -> WB.
  - MEM:
    - mem_req=1 on every MEM cycle, starting the first cycle.
    - mem_we = latched write AND NOT latched read; read wins if both are set.
    - mem_ack is sampled at each edge in MEM. ack=1 -> WB, and mem_req drops next cycle.
    - Zero-wait ack (ack on the first MEM cycle) is legal and gives a 1-cycle MEM.
  - WB:
    - pc_we=1; reg_we = latched regWrite.
    - retired increments, saturating at all-ones (no wrap).
    - -> FETCH.
  - HALT: halted=1, all strobes 0. Sticky; exit only via reset_n.
- mem_ack outside MEM is ignored; no effect on state.
- Latency per instruction:
  - Non-memory: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory: 4+k cycles, where k = number of MEM cycles (k >= 1).
- Exactly one pc_we and at most one reg_we per retired instruction. ir_load never coincides with pc_we.
- Decode inputs are only sampled in DECODE; changes at other times have no effect.

Optional Feature:
- Macro: SEQ_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to MEM and increments each MEM cycle without ack.
  - If it reaches MEM_TIMEOUT with no ack: mem_err set (sticky until reset), state -> HALT, mem_req drops next cycle.
  - Nothing is written and retired does not increment.
  - An ack on the same cycle as the timeout wins: normal WB, no error.
- Undefined:
  - No counter logic; MEM waits indefinitely.
  - mem_err tied to 0.

Test Plan:
- Reset then start=1 with a 1-cycle ALU instruction (dec_regWrite=1) -> ir_load at cycle 1, reg_we and pc_we at cycle 4, retired=1, back in FETCH at cycle 5.
- Load (dec_regWrite=1, dec_memoryRead=1), mem_ack delayed 3 cycles -> mem_req high 3 cycles with mem_we=0, then reg_we=1 in WB, total 7 cycles, retired increments by 1.
- Store (dec_memoryWrite=1), zero-wait ack -> mem_req and mem_we high for exactly 1 cycle, reg_we=0, pc_we=1, 5 cycles total; dec_memoryRead=1 and dec_memoryWrite=1 together -> mem_we=0.
- dec_halt=1 in DECODE -> halted=1 and busy=0 next cycle; retired unchanged; later start and mem_ack pulses have no effect. reset_n low asserted mid-MEM -> all outputs 0 immediately, retired=0.
- Force retired to all-ones via CNT_WIDTH=4 (15 instructions), then one more -> retired stays 4'hF.
- With SEQ_MEM_TIMEOUT_EN and MEM_TIMEOUT=15, no ack -> mem_err=1 and halted=1 after 15 MEM cycles; ack on cycle 15 -> normal WB, mem_err=0.
